// File: rtl/apb_led_seq_pkg.sv
// Shared definitions for the APB LED sequencer: register map, CTRL/STATUS bit
// positions and the sequencer state encoding.
package apb_led_seq_pkg;

    localparam logic [3:0] OFFSET_DATA   = 4'h0;
    localparam logic [3:0] OFFSET_STATUS = 4'h4;
    localparam logic [3:0] OFFSET_CTRL   = 4'h8;
    localparam logic [3:0] OFFSET_PERIOD = 4'hC;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

    localparam int STATUS_COUNT_LSB = 0;
    localparam int STATUS_COUNT_MSB = 4;
    localparam int STATUS_EMPTY     = 5;
    localparam int STATUS_FULL      = 6;
    localparam int STATUS_RUNNING   = 7;
    localparam int STATUS_SW_LSB    = 8;

    localparam int PERIOD_W = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Only address bits [3:2] select a register; this maps a byte offset to that index.
    function automatic logic [1:0] reg_index(input logic [3:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/apb_led_seq_sync_fifo.sv
// Synchronous show-ahead FIFO with a one-cycle flush; a push is refused when
// full (pre-edge count) and a flush overrides any push or pop in its cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; entries are only visible through the counted range.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_led_seq.sv
// APB-programmed LED pattern sequencer: patterns are queued through DATA and
// each is shown on led for max(PERIOD,1) cycles while CTRL.enable is set.
module apb_led_seq
    import apb_led_seq_pkg::*;
#(
    parameter int                  FIFO_DEPTH = 8,
    parameter logic [PERIOD_W-1:0] PERIOD_RST = 24'h000010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR,
    output logic [7:0]  led,
    input  logic [7:0]  sw
);

    localparam logic [1:0] IDX_DATA   = reg_index(OFFSET_DATA);
    localparam logic [1:0] IDX_STATUS = reg_index(OFFSET_STATUS);
    localparam logic [1:0] IDX_CTRL   = reg_index(OFFSET_CTRL);
    localparam logic [1:0] IDX_PERIOD = reg_index(OFFSET_PERIOD);
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;

    logic                access;
    logic                addr_ok;
    logic [1:0]          idx;
    logic                wr_access;
    logic                rd_access;
    logic                ctrl_write;
    logic                period_write;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [7:0]          fifo_dout;
    logic                enable;
    logic                flush_q;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] dwell;
    logic [PERIOD_W-1:0] dwell_next;
    logic [PERIOD_W-1:0] dwell_load;
    logic [7:0]          led_next;
    logic [7:0]          sw_meta;
    logic [7:0]          sw_sync;
    logic [31:0]         status;
    logic                pattern_ready;
    logic                unused_bits;
    state_t              state;
    state_t              state_next;

    assign PREADY       = 1'b1;
    assign access       = PSEL & PENABLE;
    assign addr_ok      = (PADDR[31:4] == 28'd0);
    assign idx          = PADDR[3:2];
    assign wr_access    = access & PWRITE & addr_ok;
    assign rd_access    = access & ~PWRITE & addr_ok;
    assign ctrl_write   = wr_access & (idx == IDX_CTRL);
    assign period_write = wr_access & (idx == IDX_PERIOD);
    assign fifo_push    = wr_access & (idx == IDX_DATA);
    assign unused_bits  = ^{PADDR[1:0], PWDATA[31:24]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush_q),
        .din   (PWDATA[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Flush is registered from the CTRL write, so it empties the FIFO on the
    // following edge and swallows any push or pop arriving in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable  <= 1'b0;
            flush_q <= 1'b0;
            period  <= PERIOD_RST;
        end else begin
            flush_q <= ctrl_write & PWDATA[CTRL_FLUSH];
            if (ctrl_write)   enable <= PWDATA[CTRL_ENABLE];
            if (period_write) period <= PWDATA[PERIOD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_comb begin
        status = '0;
        status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(fifo_count);
        status[STATUS_EMPTY]   = fifo_empty;
        status[STATUS_FULL]    = fifo_full;
        status[STATUS_RUNNING] = (state != ST_IDLE);
        status[STATUS_SW_LSB +: 8] = sw_sync;
    end

    always_comb begin
        PRDATA = '0;
        if (rd_access) begin
            case (idx)
                IDX_STATUS: PRDATA = status;
                IDX_CTRL:   PRDATA = {31'd0, enable};
                IDX_PERIOD: PRDATA = {{(32-PERIOD_W){1'b0}}, period};
                default:    PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        PSLVERR = 1'b0;
        if (access) begin
            PSLVERR = ~addr_ok
                    | (PWRITE  & (idx == IDX_STATUS))
                    | (~PWRITE & (idx == IDX_DATA))
                    | (PWRITE  & (idx == IDX_DATA) & fifo_full & ~flush_q);
        end
    end

    assign dwell_load    = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign pattern_ready = ~fifo_empty & ~flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dwell <= '0;
            led   <= 8'h00;
        end else begin
            state <= state_next;
            dwell <= dwell_next;
            led   <= led_next;
        end
    end

    // A reload at dwell 0 pops the next pattern on the same edge, so patterns
    // follow each other without an idle cycle in between.
    always_comb begin
        state_next = state;
        dwell_next = dwell;
        led_next   = led;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && pattern_ready) begin
                    fifo_pop   = 1'b1;
                    led_next   = fifo_dout;
                    dwell_next = dwell_load;
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (dwell != '0) begin
                    dwell_next = dwell - PERIOD_W'(1);
                end else if (enable && pattern_ready) begin
                    fifo_pop   = 1'b1;
                    led_next   = fifo_dout;
                    dwell_next = dwell_load;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_led_seq.sv
// Self-checking bench for apb_led_seq: register vector table, pattern timing,
// FIFO full/flush, error responses, switch sync and mid-dwell reset.
module tb_apb_led_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic [7:0]  led;
    logic [7:0]  sw;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    apb_led_seq #(
        .FIFO_DEPTH (8),
        .PERIOD_RST (24'h000010)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR),
        .led     (led),
        .sw      (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard_empty: no expectation queued for access");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (PSLVERR !== e.err) begin
            errors++;
            $display("[TB] FAIL %s pslverr: got %b expected %b", e.name, PSLVERR, e.err);
        end
        if (e.chk_rd) begin
            checks++;
            if (PRDATA !== e.rdata) begin
                errors++;
                $display("[TB] FAIL %s prdata: got %h expected %h", e.name, PRDATA, e.rdata);
            end
        end
    endtask

    task automatic checkLed(input string name, input logic [7:0] exp);
        checks++;
        if (led !== exp) begin
            errors++;
            $display("[TB] FAIL %s led: got %h expected %h", name, led, exp);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic wr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic err);
        exp_q.push_back('{name, rdata, err, ~wr});
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        checkOutput();
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0; sw = 8'h00;
        rst_n = 1'b0;

        vecs.push_back('{"status_rst",   32'h4,  1'b0, 32'h0,        32'h20, 1'b0});
        vecs.push_back('{"period_rst",   32'hC,  1'b0, 32'h0,        32'h10, 1'b0});
        vecs.push_back('{"ctrl_rst",     32'h8,  1'b0, 32'h0,        32'h0,  1'b0});
        vecs.push_back('{"data_read",    32'h0,  1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{"status_write", 32'h4,  1'b1, 32'hFFFFFFFF, 32'h0,  1'b1});
        vecs.push_back('{"bad_addr_wr",  32'h10, 1'b1, 32'h5A,       32'h0,  1'b1});
        vecs.push_back('{"bad_addr_rd",  32'h10, 1'b0, 32'h0,        32'h0,  1'b1});
        vecs.push_back('{"status_clean", 32'h4,  1'b0, 32'h0,        32'h20, 1'b0});
        vecs.push_back('{"period_wr",    32'hC,  1'b1, 32'hFF000007, 32'h0,  1'b0});
        vecs.push_back('{"period_rd",    32'hC,  1'b0, 32'h0,        32'h7,  1'b0});
        vecs.push_back('{"ctrl_wr",      32'h8,  1'b1, 32'h3,        32'h0,  1'b0});
        vecs.push_back('{"ctrl_rd",      32'h8,  1'b0, 32'h0,        32'h1,  1'b0});
        vecs.push_back('{"ctrl_off",     32'h8,  1'b1, 32'h0,        32'h0,  1'b0});
        vecs.push_back('{"ctrl_rd_off",  32'h8,  1'b0, 32'h0,        32'h0,  1'b0});

        repeat (3) @(posedge clk);
        #1;
        checkLed("led_in_reset", 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                          vecs[i].rdata, vecs[i].err);

        // Three patterns at PERIOD=3: A5,5A,FF back to back, then hold FF.
        applyStimulus("period3", 32'hC, 1'b1, 32'h3, 32'h0, 1'b0);
        applyStimulus("push_a5", 32'h0, 1'b1, 32'hA5, 32'h0, 1'b0);
        applyStimulus("push_5a", 32'h0, 1'b1, 32'h5A, 32'h0, 1'b0);
        applyStimulus("push_ff", 32'h0, 1'b1, 32'hFF, 32'h0, 1'b0);
        applyStimulus("status_q3", 32'h4, 1'b0, 32'h0, 32'h03, 1'b0);
        applyStimulus("enable_on", 32'h8, 1'b1, 32'h1, 32'h0, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            logic [7:0] exp_led;
            @(negedge clk);
            if (k == 0)      exp_led = 8'h00;
            else if (k <= 3) exp_led = 8'hA5;
            else if (k <= 6) exp_led = 8'h5A;
            else             exp_led = 8'hFF;
            checkLed($sformatf("seq_cycle%0d", k), exp_led);
        end
        applyStimulus("status_done", 32'h4, 1'b0, 32'h0, 32'h20, 1'b0);
        checkLed("hold_ff", 8'hFF);

        // Fill the FIFO with enable off; the ninth write must be refused.
        applyStimulus("enable_off", 32'h8, 1'b1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 9; i++)
            applyStimulus($sformatf("fill%0d", i + 1), 32'h0, 1'b1, 32'h10 + i, 32'h0, i == 8);
        applyStimulus("status_full", 32'h4, 1'b0, 32'h0, 32'h48, 1'b0);
        applyStimulus("flush_full", 32'h8, 1'b1, 32'h2, 32'h0, 1'b0);
        applyStimulus("status_flushed", 32'h4, 1'b0, 32'h0, 32'h20, 1'b0);

        // Flush during SHOW with a DATA write landing in the flush cycle.
        applyStimulus("period40", 32'hC, 1'b1, 32'h28, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus($sformatf("q%0d", i), 32'h0, 1'b1, 32'h11 * (i + 1), 32'h0, 1'b0);
        applyStimulus("enable_show", 32'h8, 1'b1, 32'h1, 32'h0, 1'b0);
        applyStimulus("status_show", 32'h4, 1'b0, 32'h0, 32'h84, 1'b0);
        checkLed("show_first", 8'h11);
        exp_q.push_back('{"flush_ctrl", 32'h0, 1'b0, 1'b0});
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h8; PWRITE = 1'b1; PWDATA = 32'h3;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        checkOutput();
        @(posedge clk); #1;
        PADDR = 32'h0; PWDATA = 32'h99;
        exp_q.push_back('{"data_in_flush", 32'h0, 1'b0, 1'b0});
        @(negedge clk);
        checkOutput();
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        applyStimulus("status_after_flush", 32'h4, 1'b0, 32'h0, 32'hA0, 1'b0);
        checkLed("flush_keeps_led", 8'h11);
        repeat (45) @(posedge clk);
        applyStimulus("status_idle", 32'h4, 1'b0, 32'h0, 32'h20, 1'b0);
        checkLed("hold_after_flush", 8'h11);

        // Switch synchroniser.
        @(posedge clk); #1;
        sw = 8'h3C;
        applyStimulus("status_sw", 32'h4, 1'b0, 32'h0, 32'h3C20, 1'b0);
        sw = 8'h00;
        repeat (3) @(posedge clk);

        // Reset in the middle of a dwell.
        applyStimulus("rst_off", 32'h8, 1'b1, 32'h0, 32'h0, 1'b0);
        applyStimulus("period20", 32'hC, 1'b1, 32'h14, 32'h0, 1'b0);
        applyStimulus("push_c1", 32'h0, 1'b1, 32'hC1, 32'h0, 1'b0);
        applyStimulus("push_c2", 32'h0, 1'b1, 32'hC2, 32'h0, 1'b0);
        applyStimulus("push_c3", 32'h0, 1'b1, 32'hC3, 32'h0, 1'b0);
        applyStimulus("rst_on", 32'h8, 1'b1, 32'h1, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        checkLed("before_reset", 8'hC1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkLed("async_reset", 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus("status_post_rst", 32'h4, 1'b0, 32'h0, 32'h20, 1'b0);
        applyStimulus("period_post_rst", 32'hC, 1'b0, 32'h0, 32'h10, 1'b0);
        applyStimulus("ctrl_post_rst", 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus("reenable", 32'h8, 1'b1, 32'h1, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        checkLed("no_stale_pattern", 8'h00);
        applyStimulus("status_reenabled", 32'h4, 1'b0, 32'h0, 32'h20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_led_seq.md
APB_LED_SEQ -- requirements
Module: apb_led_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, LED pattern FIFO entries (power of two).
REQ-002 SHALL have parameter PERIOD_RST, default 24'h000010, reset value of the PERIOD register.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PADDR  input  32  APB address; only [3:2] decoded, [31:4] must be zero.
REQ-006 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB slave control.
REQ-007 SHALL have port PWDATA  input  32  APB write data.
REQ-008 SHALL have port PREADY  output  1  tied high; zero wait states.
REQ-009 SHALL have port PRDATA  output  32  APB read data.
REQ-010 SHALL have port PSLVERR  output  1  APB error response.
REQ-011 SHALL have port led  output  8  displayed pattern.
REQ-012 SHALL have port sw  input  8  asynchronous board switches.

Function
REQ-013 SHALL treat PSEL&PENABLE as the access phase; writes commit on the clk edge ending the access phase; PRDATA and PSLVERR are combinational and valid during the access phase; PRDATA and PSLVERR are 0 outside it.
REQ-014 SHALL decode four registers: 0x0 DATA (W), 0x4 STATUS (R), 0x8 CTRL (RW), 0xC PERIOD (RW).
REQ-015 SHALL assert PSLVERR for: a nonzero PADDR[31:4]; a write to STATUS; a read of DATA (returns 0); a DATA write while the FIFO is full (the pattern is dropped).
REQ-016 SHALL push PWDATA[7:0] on a DATA write when count < FIFO_DEPTH, where count is the pre-edge value; a same-cycle pop does not make room.
REQ-017 SHALL read STATUS as: [4:0] count, [5] empty, [6] full, [7] running (FSM not IDLE), [15:8] synchronised sw, other bits 0.
REQ-018 SHALL define CTRL as: [0] enable (RW); [1] flush (write-1 pulse, always reads 0).
REQ-019 SHALL make flush empty the FIFO in one cycle without changing led; a push in the same cycle as flush is discarded without PSLVERR.
REQ-020 SHALL define PERIOD as: [23:0] dwell in cycles (RW), [31:24] reading 0; a value of 0 behaves as 1.
REQ-021 SHALL implement an FSM with states IDLE and SHOW.
REQ-022 In IDLE, when enable=1 and the FIFO is non-empty, SHALL pop the head into led, load dwell counter = max(PERIOD,1)-1, and go to SHOW; led changes one cycle after the popping edge is reached.
REQ-023 In SHOW, SHALL decrement the counter each cycle; at counter 0: if enable=1 and the FIFO is non-empty, pop the next entry and reload (no gap cycle); otherwise go to IDLE.
REQ-024 SHALL hold led after the final pattern; each pattern is displayed for exactly max(PERIOD,1) cycles.
REQ-025 Clearing enable mid-SHOW SHALL NOT abort the current dwell; the FSM returns to IDLE at counter 0.
REQ-026 A PERIOD write during SHOW SHALL take effect at the next reload only.
REQ-027 SHALL synchronise sw through two flip-flops before it is visible in STATUS.
REQ-028 The FIFO read and write pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; count is a separate log2(FIFO_DEPTH)+1-bit counter.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: FSM to IDLE, FIFO empty, pointers and count to 0, led to 8'h00, enable to 0, PERIOD to PERIOD_RST, dwell counter to 0, sw synchronisers to 0.
REQ-030 Reset asserted mid-SHOW SHALL discard all queued patterns; operation resumes only after software re-enables the block.

Structure
REQ-031 SHALL place the register offsets (0x0/0x4/0x8/0xC), the CTRL/STATUS bit positions, and the FSM state encoding in a shared package apb_led_seq_pkg.
REQ-032 SHALL implement the FIFO as one sub-module, sync_fifo (parameterised on width and depth, with push/pop/full/empty/count ports); the APB decode and FSM live in the top level.

Verification
REQ-033 Reset, then read 0x4 -> 0x0000_0020 (empty) with sw-derived bits only; led=0x00; PERIOD reads 0x10.
REQ-034 With PERIOD=3, write 0xA5, 0x5A, 0xFF to DATA, then CTRL=1 -> led shows A5, 5A, FF for 3 cycles each with no gaps, then holds FF; STATUS[7] returns to 0.
REQ-035 Write 9 patterns with enable=0 -> writes 1-8 complete with PSLVERR=0; write 9 gives PSLVERR=1; STATUS count=8 and full=1.
REQ-036 With 4 patterns queued, write CTRL=0x2 during SHOW -> count=0 and the current led is unchanged; a DATA write in the same flush cycle is dropped.
REQ-037 Read 0x0, write 0x4, and access PADDR=0x10 -> PSLVERR=1 for each and no register changes; set sw=0x3C -> STATUS[15:8]=0x3C within 3 cycles.
REQ-038 Pulse rst_n low mid-dwell -> led=0x00 and the FSM is IDLE immediately; re-enabling with no new writes produces no led change.
